// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle-factor generator: default sizes,
// sequencer state encoding and the quarter-wave cosine table function.
package twiddle_pkg;

    localparam int DEF_LOG2N = 3;
    localparam int DEF_WIDTH = 16;
    localparam int N         = 1 << DEF_LOG2N;
    localparam int QUARTER   = N / 4;
    localparam int ONE       = 1 << (DEF_WIDTH - 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // round(cos(2*pi*m/2^log2n) * 2^(width-2)); Taylor series is exact enough over [0, pi/2].
    function automatic int cos_q(input int m, input int log2n, input int width);
        real x;
        real term;
        real acc;
        x    = 2.0 * 3.14159265358979323846 * real'(m) / real'(1 << log2n);
        term = 1.0;
        acc  = 1.0;
        for (int i = 1; i <= 16; i++) begin
            term = -term * x * x / real'((2 * i - 1) * (2 * i));
            acc  = acc + term;
        end
        acc = acc * real'(1 << (width - 2));
        return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Registered dual-read quarter-wave cosine ROM, N/4+1 entries, contents
// fixed at elaboration.
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [LOG2N-2:0]        addr_a,
    input  logic [LOG2N-2:0]        addr_b,
    output logic signed [WIDTH-1:0] data_a,
    output logic signed [WIDTH-1:0] data_b
);

    localparam int DEPTH = (1 << (LOG2N - 2)) + 1;

    logic signed [WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int VAL = cos_q(i, LOG2N, WIDTH);
        assign rom[i] = WIDTH'(VAL);
    end

    // NOTE: ROM data registers carry no reset; validity is tracked by the
    // pipeline valid bits, so resetting the data path would only cost logic.
    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator: direct requests or per-stage sequences, folded
// from a quarter-wave ROM, through a stallable 2-stage pipeline.
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int WIDTH = 16,
    parameter int STW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [LOG2N-1:0]        req_k,
    output logic                    req_ready,
    input  logic                    inv,
    input  logic                    seq_start,
    input  logic [STW-1:0]          seq_stage,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic signed [WIDTH-1:0] Wreal,
    output logic signed [WIDTH-1:0] Wimag
);

    localparam int NPT = 1 << LOG2N;
    localparam int QTR = NPT / 4;
    localparam int AW  = LOG2N - 1;
    localparam int JW  = LOG2N - 1;

    seq_state_e     state, state_nxt;
    logic [JW-1:0]  j_cnt;
    logic [STW-1:0] stage_q;
    logic           inv_q;

    logic stall, en, accept, seq_go, seq_issue, seq_last;
    logic [LOG2N-1:0] seq_k, s1_k_nxt;
    logic s1_inv_nxt, s1_last_nxt;

    logic          s1_valid, s1_inv, s1_last;
    logic [1:0]    s1_q;
    logic [AW-1:0] s1_m;

    logic                    s2_valid, s2_inv, s2_last;
    logic [1:0]              s2_q;
    logic signed [WIDTH-1:0] rom_a, rom_b, fold_re, fold_im;

    assign stall     = out_valid && !out_ready;
    assign en        = !stall;
    assign busy      = (state == RUN);
    assign req_ready = !rst && !busy && !stall && !seq_start;
    assign accept    = req_valid && req_ready;
    assign seq_go    = (state == IDLE) && seq_start && en && (int'(seq_stage) < LOG2N);
    assign seq_issue = (state == RUN) && en;
    assign seq_last  = (j_cnt == JW'(NPT / 2 - 1));

    // k = (j mod 2^s) << (LOG2N-1-s)
    always_comb begin
        int jm;
        jm    = int'(j_cnt) & ((1 << stage_q) - 1);
        seq_k = LOG2N'(jm << (LOG2N - 1 - int'(stage_q)));
    end

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (seq_go) state_nxt = RUN;
            RUN:  if (seq_issue && seq_last) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            j_cnt   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (seq_go) begin
                j_cnt   <= '0;
                stage_q <= seq_stage;
                inv_q   <= inv;
            end else if (seq_issue) begin
                j_cnt <= j_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        s1_k_nxt    = req_k;
        s1_inv_nxt  = inv;
        s1_last_nxt = 1'b0;
        if (seq_issue) begin
            s1_k_nxt    = seq_k;
            s1_inv_nxt  = inv_q;
            s1_last_nxt = seq_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= seq_issue || accept;
            s1_q     <= s1_k_nxt[LOG2N-1 -: 2];
            s1_m     <= AW'(s1_k_nxt) & AW'(QTR - 1);
            s1_inv   <= s1_inv_nxt;
            s1_last  <= s1_last_nxt;
            s2_valid <= s1_valid;
            s2_q     <= s1_q;
            s2_inv   <= s1_inv;
            s2_last  <= s1_last;
        end
    end

    twiddle_qrom #(
        .LOG2N (LOG2N),
        .WIDTH (WIDTH)
    ) u_qrom (
        .clk    (clk),
        .en     (en),
        .addr_a (s1_m),
        .addr_b (AW'(QTR) - s1_m),
        .data_a (rom_a),
        .data_b (rom_b)
    );

    // Quadrant fold: A = C[m], B = C[N/4-m]; inverse conjugates afterwards.
    always_comb begin
        fold_re = rom_a;
        fold_im = -rom_b;
        case (s2_q)
            2'd0:    begin fold_re = rom_a;  fold_im = -rom_b; end
            2'd1:    begin fold_re = -rom_b; fold_im = -rom_a; end
            2'd2:    begin fold_re = -rom_a; fold_im = rom_b;  end
            default: begin fold_re = rom_b;  fold_im = rom_a;  end
        endcase
        if (s2_inv) fold_im = -fold_im;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            Wreal     <= '0;
            Wimag     <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                Wreal    <= fold_re;
                Wimag    <= fold_im;
                out_last <= s2_last;
            end
        end
    end

endmodule
